cla_pipe_adder: RTL and testbench
=================================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter GRP, default 4, bits per lookahead group; WIDTH SHALL be an integer multiple of GRP.
REQ-003 SHALL have parameter LAT, default 2, pipeline latency in cycles; legal values 1, 2, 3.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  pipeline advance enable.
REQ-007 SHALL have port in_valid  input  1  operand qualifier.
REQ-008 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-009 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-010 SHALL have port b  input  WIDTH  operand B.
REQ-011 SHALL have port cin  input  1  carry-in when adding, borrow-in when subtracting.
REQ-012 SHALL have port sum  output  WIDTH  result, registered.
REQ-013 SHALL have port cout  output  1  carry-out when adding, inverted borrow-out when subtracting, registered.
REQ-014 SHALL have port ovf  output  1  signed overflow of the result, registered.
REQ-015 SHALL have port out_valid  output  1  qualifies sum/cout/ovf, registered.

Function
REQ-016 SHALL form B' = sub ? ~b : b and effective carry-in ci = sub ? ~cin : cin, so that add = a+b+cin and subtract = a-b-cin.
REQ-017 SHALL compute per-bit p = a^B' and g = a&B', and per-group P/G plus in-group carries by two-level lookahead: group carry c[k+1] = G[k] | (P[k] & c[k]), with c[0] = ci.
REQ-018 SHALL produce sum[i] = p[i] ^ carry-into-bit-i, cout = carry out of bit WIDTH-1, and ovf = carry into MSB XOR carry out of MSB.
REQ-019 SHALL place registers as follows: LAT=1, output register only; LAT=2, adds a register after per-bit p/g and group P/G; LAT=3, also adds a register after group carries.
REQ-020 SHALL carry in_valid and operand-derived data through every pipeline register, so out_valid asserts exactly LAT enabled cycles after the in_valid sample.
REQ-021 SHALL, when en=1, advance all pipeline registers, including valid bits, on every rising edge.
REQ-022 SHALL, when en=0, hold all pipeline registers and all outputs unchanged; inputs presented while en=0 are ignored.
REQ-023 SHALL accept one operation per enabled cycle (full throughput) with no bubbles, including back-to-back operations with differing sub values.
REQ-024 SHALL advance data registers of invalid slots normally; their contents are don't-care but SHALL NOT assert out_valid.
REQ-025 SHALL produce wrap-around results modulo 2^WIDTH; there is no saturation.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, clear every pipeline register, sum, cout, ovf and out_valid to 0, regardless of en.
REQ-027 SHALL drop operations in flight when rst asserts mid-operation; none SHALL emerge after reset releases.
REQ-028 SHALL accept a new operand on the first edge with rst=0 and en=1.

Verification
REQ-029 SHALL verify basic add, carry chain and latency (WIDTH=16, LAT=2): a=0xFFFF, b=0x0001, cin=0, sub=0, in_valid=1 -> 2 cycles later sum=0x0000, cout=1, ovf=0, out_valid=1.
REQ-030 SHALL verify subtract with borrow (WIDTH=16, GRP=4): a=0x0005, b=0x0007, cin=1, sub=1 -> sum=0xFFFD, cout=0, ovf=0.
REQ-031 SHALL verify signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0; also a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1, cout=1.
REQ-032 SHALL verify stall: issue 3 back-to-back operations, deassert en for 4 cycles mid-stream -> outputs frozen during the stall; the results then emerge in order with correct values and no duplicates.
REQ-033 SHALL verify reset mid-flight (LAT=3): assert rst 1 cycle after in_valid -> all outputs 0 and out_valid never asserts for that operation.
REQ-034 SHALL verify against a reference model: 10k random operands for each LAT in {1,2,3} and GRP in {2,4,8}, with random en, sub and in_valid -> every sum/cout/ovf matches a+-b+-cin modulo 2^WIDTH.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. The operands are split into
// groups of GRP bits. Each group forms its own propagate/generate pair. The
// group carries then ripple across groups, and each group resolves its own
// bit carries from its incoming group carry.
//
// LAT selects where the pipeline registers sit:
//   LAT=1 : output register only
//   LAT=2 : adds a register after the per-bit p/g and group P/G
//   LAT=3 : also adds a register after the group carries
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears every register
//   en         pipeline advance enable; when low, everything holds
//   in_valid   qualifies the operands presented this cycle
//   sub        0 = a + b + cin, 1 = a - b - cin
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry-in (add) or borrow-in (subtract)
//   sum        registered result, modulo 2^WIDTH
//   cout       registered carry-out (add) or inverted borrow-out (subtract)
//   ovf        registered signed overflow flag
//   out_valid  registered qualifier for sum/cout/ovf
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
   parameter int WIDTH = 64,
   parameter int GRP   = 4,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   localparam int NG = WIDTH / GRP;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p0, g0;
   logic [NG-1:0]    gp0, gg0;
   logic             ci0;

   logic [WIDTH-1:0] p1, g1;
   logic [NG-1:0]    gp1, gg1;
   logic             ci1, v1;

   logic [NG:0]      gc1;

   logic [WIDTH-1:0] p2, g2;
   logic [NG:0]      gc2;
   logic             v2;

   logic [WIDTH-1:0] bit_c;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d, ovf_d;

   // Subtraction is done as a + ~b + ~cin, which equals a - b - cin.
   // This lets one carry network serve both modes.
   assign b_eff = sub ? ~b : b;
   assign ci0   = sub ? ~cin : cin;
   assign p0    = a ^ b_eff;
   assign g0    = a & b_eff;

   // Collapse each group of GRP bits into one propagate/generate pair.
   // A group propagates only if every bit propagates. It generates if some
   // bit generates and all the bits above it propagate.
   always_comb begin
      logic gen_acc;
      logic prop_acc;
      gp0 = '0;
      gg0 = '0;
      for (int k = 0; k < NG; k++) begin
         gen_acc  = 1'b0;
         prop_acc = 1'b1;
         for (int j = 0; j < GRP; j++) begin
            gen_acc  = g0[k*GRP+j] | (p0[k*GRP+j] & gen_acc);
            prop_acc = prop_acc & p0[k*GRP+j];
         end
         gg0[k] = gen_acc;
         gp0[k] = prop_acc;
      end
   end

   // Optional first pipeline register, after the per-bit and per-group
   // propagate/generate terms. The effective carry-in and the valid bit
   // travel alongside so the slot stays self-contained.
   generate
      if (LAT >= 2) begin : g_stage1_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               p1  <= '0;
               g1  <= '0;
               gp1 <= '0;
               gg1 <= '0;
               ci1 <= 1'b0;
               v1  <= 1'b0;
            end else if (en) begin
               p1  <= p0;
               g1  <= g0;
               gp1 <= gp0;
               gg1 <= gg0;
               ci1 <= ci0;
               v1  <= in_valid;
            end
         end
      end else begin : g_stage1_wire
         assign p1  = p0;
         assign g1  = g0;
         assign gp1 = gp0;
         assign gg1 = gg0;
         assign ci1 = ci0;
         assign v1  = in_valid;
      end
   endgenerate

   // Second lookahead level: carry into each group. gc1[k] is the carry
   // entering group k, and gc1[NG] is the carry out of the whole word.
   always_comb begin
      logic c_run;
      gc1    = '0;
      c_run  = ci1;
      gc1[0] = c_run;
      for (int k = 0; k < NG; k++) begin
         c_run    = gg1[k] | (gp1[k] & c_run);
         gc1[k+1] = c_run;
      end
   end

   // Optional second pipeline register, after the group carries. Only the
   // per-bit p/g and the group carries are needed past this point.
   generate
      if (LAT >= 3) begin : g_stage2_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               p2  <= '0;
               g2  <= '0;
               gc2 <= '0;
               v2  <= 1'b0;
            end else if (en) begin
               p2  <= p1;
               g2  <= g1;
               gc2 <= gc1;
               v2  <= v1;
            end
         end
      end else begin : g_stage2_wire
         assign p2  = p1;
         assign g2  = g1;
         assign gc2 = gc1;
         assign v2  = v1;
      end
   endgenerate

   // Resolve the carry into every bit, starting from the carry that enters
   // its group. Overflow compares the carry into the MSB with the carry out
   // of the MSB.
   always_comb begin
      logic c_run;
      bit_c = '0;
      for (int k = 0; k < NG; k++) begin
         c_run = gc2[k];
         for (int j = 0; j < GRP; j++) begin
            bit_c[k*GRP+j] = c_run;
            c_run          = g2[k*GRP+j] | (p2[k*GRP+j] & c_run);
         end
      end
   end

   assign sum_d  = p2 ^ bit_c;
   assign cout_d = gc2[NG];
   assign ovf_d  = bit_c[WIDTH-1] ^ gc2[NG];

   // Output register, present for every LAT value. It holds while en is low
   // and clears on reset regardless of en.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (en) begin
         sum       <= sum_d;
         cout      <= cout_d;
         ovf       <= ovf_d;
         out_valid <= v2;
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Three adders share one stimulus stream (WIDTH=16):
//   LAT=1 with GRP=2, LAT=2 with GRP=4, LAT=3 with GRP=8.
// A behavioural model does plain integer arithmetic on every enabled edge
// and keeps a short history. The expected output of a LAT=n adder is the
// entry recorded n enabled edges ago. Reset refills the history with cleared
// slots.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

   localparam int W = 16;

   typedef struct packed {
      logic         valid;
      logic         care;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   localparam exp_t ZERO_E = '{valid: 1'b0, care: 1'b1, sum: '0, cout: 1'b0, ovf: 1'b0};

   logic         clk = 1'b0;
   logic         rst, en, in_valid, sub, cin;
   logic [W-1:0] a, b;

   logic [W-1:0] sum_l1, sum_l2, sum_l3;
   logic         cout_l1, cout_l2, cout_l3;
   logic         ovf_l1, ovf_l2, ovf_l3;
   logic         ovld_l1, ovld_l2, ovld_l3;

   int n_vec  = 0;
   int n_miss = 0;
   int vcnt2  = 0;
   int vcnt3  = 0;

   exp_t hist[$];
   bit   model_live = 1'b0;
   bit   last_adv   = 1'b0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(W), .GRP(2), .LAT(1)) dut_l1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a), .b(b), .cin(cin),
      .sum(sum_l1), .cout(cout_l1), .ovf(ovf_l1), .out_valid(ovld_l1)
   );

   cla_pipe_adder #(.WIDTH(W), .GRP(4), .LAT(2)) dut_l2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a), .b(b), .cin(cin),
      .sum(sum_l2), .cout(cout_l2), .ovf(ovf_l2), .out_valid(ovld_l2)
   );

   cla_pipe_adder #(.WIDTH(W), .GRP(8), .LAT(3)) dut_l3 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
      .a(a), .b(b), .cin(cin),
      .sum(sum_l3), .cout(cout_l3), .ovf(ovf_l3), .out_valid(ovld_l3)
   );

   // Reference arithmetic on plain integers. Subtract reports carry-out as
   // "no borrow". Overflow means the true signed result does not fit in W bits.
   function automatic exp_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic s, input logic c, input logic v);
      exp_t   e;
      longint ua, ub, sa, sb, ci, ut, st;
      ua = longint'(av);
      ub = longint'(bv);
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ci = c ? 64'sd1 : 64'sd0;
      if (s) begin
         ut     = ua - ub - ci;
         st     = sa - sb - ci;
         e.cout = (ut >= 0);
      end else begin
         ut     = ua + ub + ci;
         st     = sa + sb + ci;
         e.cout = (ut >= (longint'(1) << W));
      end
      e.sum   = ut[W-1:0];
      e.ovf   = (st > ((longint'(1) << (W-1)) - 1)) || (st < -(longint'(1) << (W-1)));
      e.valid = v;
      e.care  = v;
      return e;
   endfunction

   // Model update on each clock edge: reset empties the pipeline, an enabled
   // edge records one new slot, and a disabled edge changes nothing.
   always @(posedge clk) begin
      if (rst) begin
         hist.delete();
         repeat (3) hist.push_back(ZERO_E);
         model_live = 1'b1;
         last_adv   = 1'b0;
      end else if (en) begin
         hist.push_back(ref_op(a, b, sub, cin, in_valid));
         if (hist.size() > 8) void'(hist.pop_front());
         last_adv = 1'b1;
      end else begin
         last_adv = 1'b0;
      end
   end

   // Compare every adder against the model on each falling edge. Data is
   // checked only where it is defined: valid slots and freshly cleared slots.
   exp_t         cmp_e;
   logic         cmp_v, cmp_c, cmp_o;
   logic [W-1:0] cmp_s;
   always @(negedge clk) begin
      if (model_live) begin
         for (int d = 0; d < 3; d++) begin
            cmp_e = hist[hist.size()-1-d];
            case (d)
               0:       begin cmp_v = ovld_l1; cmp_s = sum_l1; cmp_c = cout_l1; cmp_o = ovf_l1; end
               1:       begin cmp_v = ovld_l2; cmp_s = sum_l2; cmp_c = cout_l2; cmp_o = ovf_l2; end
               default: begin cmp_v = ovld_l3; cmp_s = sum_l3; cmp_c = cout_l3; cmp_o = ovf_l3; end
            endcase
            n_vec++;
            if (cmp_v !== cmp_e.valid) begin
               n_miss++;
               $display("[TB] FAIL out_valid_lat%0d t=%0t: got %b, want %b", d+1, $time, cmp_v, cmp_e.valid);
            end
            if (cmp_e.care) begin
               n_vec++;
               if ({cmp_s, cmp_c, cmp_o} !== {cmp_e.sum, cmp_e.cout, cmp_e.ovf}) begin
                  n_miss++;
                  $display("[TB] FAIL result_lat%0d t=%0t: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                           d+1, $time, cmp_s, cmp_c, cmp_o, cmp_e.sum, cmp_e.cout, cmp_e.ovf);
               end
            end
            if (d == 1 && last_adv && cmp_v === 1'b1) vcnt2++;
            if (d == 2 && cmp_v === 1'b1) vcnt3++;
         end
      end
   end

   // Drive one cycle of inputs, then return just after the next falling edge.
   task automatic applyStimulus(input logic r, input logic e, input logic v, input logic s,
                                input logic c, input logic [W-1:0] av, input logic [W-1:0] bv);
      rst      = r;
      en       = e;
      in_valid = v;
      sub      = s;
      cin      = c;
      a        = av;
      b        = bv;
      @(negedge clk);
      #1;
   endtask

   // Check one adder's outputs against literal values.
   task automatic checkOutput(input string name, input int d, input logic ev,
                              input logic [W-1:0] es, input logic ec, input logic eo);
      logic         gv, gc, go;
      logic [W-1:0] gs;
      case (d)
         0:       begin gv = ovld_l1; gs = sum_l1; gc = cout_l1; go = ovf_l1; end
         1:       begin gv = ovld_l2; gs = sum_l2; gc = cout_l2; go = ovf_l2; end
         default: begin gv = ovld_l3; gs = sum_l3; gc = cout_l3; go = ovf_l3; end
      endcase
      n_vec++;
      if ({gv, gs, gc, go} !== {ev, es, ec, eo}) begin
         n_miss++;
         $display("[TB] FAIL %s: got v=%b sum=%h cout=%b ovf=%b, want v=%b sum=%h cout=%b ovf=%b",
                  name, gv, gs, gc, go, ev, es, ec, eo);
      end
   endtask

   // Pin the reference model to hand-computed results.
   task automatic checkModel(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic s, input logic c,
                             input logic [W-1:0] es, input logic ec, input logic eo);
      exp_t e;
      e = ref_op(av, bv, s, c, 1'b1);
      n_vec++;
      if ({e.sum, e.cout, e.ovf} !== {es, ec, eo}) begin
         n_miss++;
         $display("[TB] FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  name, e.sum, e.cout, e.ovf, es, ec, eo);
      end
   endtask

   // One isolated operation. The LAT=2 adder must present the literal result
   // exactly two enabled edges after the operands are sampled.
   task automatic runDirected(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic s, input logic c,
                              input logic [W-1:0] es, input logic ec, input logic eo);
      applyStimulus(1'b0, 1'b1, 1'b1, s, c, av, bv);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput(name, 1, 1'b1, es, ec, eo);
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

      checkModel("model_add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      checkModel("model_sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
      checkModel("model_add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      checkModel("model_sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      checkModel("model_add_cin",    16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);

      // Reset with en low must still clear everything.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      checkOutput("reset_lat1", 0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("reset_lat2", 1, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("reset_lat3", 2, 1'b0, '0, 1'b0, 1'b0);

      runDirected("add_carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      runDirected("sub_with_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
      runDirected("add_signed_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      runDirected("sub_signed_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

      // Back-to-back operations with alternating add/subtract.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

      // Stall mid-stream. Inputs presented while en is low must be ignored,
      // and exactly three results must emerge.
      vcnt2 = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1111);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h0FFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF000, 16'h2000);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
      repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("stall_still_idle", 1, 1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if (vcnt2 != 3) begin
         n_miss++;
         $display("[TB] FAIL stall_result_count: got %0d, want 3", vcnt2);
      end

      // Reset one cycle after an operation enters the LAT=3 adder. The
      // dropped operation must never appear. The first edge after release
      // must accept a new operation.
      vcnt3 = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'h0101);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("midflight_reset_lat3", 2, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      n_vec++;
      if (vcnt3 != 0) begin
         n_miss++;
         $display("[TB] FAIL dropped_op_emerged: got %0d valid cycles, want 0", vcnt3);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("first_after_reset_lat3", 2, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // Random traffic with occasional stalls, bubbles and resets.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
                       pickOperand(), pickOperand());
      end
      repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
